// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multi-cycle MIPS control FSM and its datapath.
//
// Handshake: the controller holds mem_req (plus mem_we/iord) steady in a
// memory state until the memory returns mem_ready=1 in the same cycle; that
// cycle completes the transfer and the FSM advances on the next rising edge.
// mem_ready has no meaning while mem_req is 0.
//
// Signals:
//   op, funct      instruction fields from the IR (to controller)
//   alu_ov         ALU OV result, used as branch-taken / overflow
//   mem_ready      memory completes the current request this cycle
//   alu_func       ALU function code
//   alu_src_a/b    ALU operand selects
//   pc_write/src   PC load enable and source select
//   mem_req/we     memory request / write
//   iord           memory address select (0=PC, 1=ALUOut)
//   ir_write       IR load enable
//   reg_write/dst  register file write enable / destination select
//   mem_to_reg     register file write data select
//   trap           sticky fault flag
//   state          current FSM state (debug)
// Modports: master = control FSM, slave = datapath side.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       alu_ov;
    logic       mem_ready;
    logic [5:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       trap;
    logic [3:0] state;

    modport master (
        input  op, funct, alu_ov, mem_ready,
        output alu_func, alu_src_a, alu_src_b, pc_write, pc_src, mem_req,
               mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               trap, state
    );

    modport slave (
        output op, funct, alu_ov, mem_ready,
        input  alu_func, alu_src_a, alu_src_b, pc_write, pc_src, mem_req,
               mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               trap, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control unit. Sequences FETCH/DECODE and the
// per-instruction execute/memory/writeback states, driving ALU function and
// datapath mux/enable lines. Outputs are combinational from state, except
// FETCH ir_write/pc_write (gated by mem_ready) and BRANCH pc_write (alu_ov).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (state -> FETCH, requests held off)
//   bus    mc_ctrl_if.master (instruction fields, ALU OV, memory handshake
//          in; control lines, trap flag and debug state out)
//
// Build option: define OVF_TRAP_EN to trap on signed overflow of add, sub
// and addi instead of writing the result back.
module mc_ctrl_fsm (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] F_ADD = 6'b000010;

    state_t     state_q, state_d;
    logic [5:0] func;
    logic       src_a, pc_wr, mem_req, mem_we, iord, ir_wr;
    logic       reg_wr, reg_dst, mem_to_reg, trap;
    logic [1:0] src_b, pc_src;
    logic       ovf;

`ifdef OVF_TRAP_EN
    assign ovf = bus.alu_ov;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        func       = F_ADD;
        src_a      = 1'b0;
        src_b      = 2'b00;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        trap       = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                src_b   = 2'b01;   // PC + 4 on the ALU while fetching
                if (bus.mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                src_b = 2'b11;     // branch target precomputed into ALUOut
                case (bus.op)
                    6'b000000:                          state_d = R_EXEC;
                    6'b100011, 6'b101011:               state_d = MEM_ADDR;
                    6'b000100, 6'b000101:               state_d = BRANCH;
                    6'b000010:                          state_d = JUMP;
                    6'b001000, 6'b001100, 6'b001101,
                    6'b001110, 6'b001011:               state_d = I_EXEC;
                    default:                            state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                src_a = 1'b1;
                src_b = 2'b10;
                if (bus.op == 6'b100011)      state_d = MEM_RD;
                else if (bus.op == 6'b101011) state_d = MEM_WR;
                else                          state_d = TRAP;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            R_EXEC: begin
                src_a   = 1'b1;
                state_d = R_WB;
                case (bus.funct)
                    6'b100000: begin func = 6'b000010; if (ovf) state_d = TRAP; end
                    6'b100010: begin func = 6'b000100; if (ovf) state_d = TRAP; end
                    6'b100100: func = 6'b001000;
                    6'b100101: func = 6'b010000;
                    6'b100111: func = 6'b100000;
                    6'b100110: func = 6'b010001;
                    6'b101011: func = 6'b000101;
                    6'b101010: func = 6'b001001;
                    default:   state_d = TRAP;
                endcase
            end
            R_WB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
                state_d = FETCH;
            end
            I_EXEC: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                state_d = I_WB;
                case (bus.op)
                    6'b001000: begin func = 6'b000010; if (ovf) state_d = TRAP; end
                    6'b001100: func = 6'b001000;
                    6'b001101: func = 6'b010000;
                    6'b001110: func = 6'b010001;
                    6'b001011: func = 6'b000101;
                    default:   func = F_ADD;
                endcase
            end
            I_WB: begin
                reg_wr  = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                src_a   = 1'b1;
                pc_src  = 2'b01;
                // ALU compare result on OV decides whether the target is taken
                func    = (bus.op == 6'b000101) ? 6'b100001 : 6'b100011;
                pc_wr   = bus.alu_ov;
                state_d = FETCH;
            end
            JUMP: begin
                pc_wr   = 1'b1;
                pc_src  = 2'b10;
                state_d = FETCH;
            end
            TRAP: begin
                trap    = 1'b1;
                state_d = TRAP;
            end
            default: state_d = TRAP;
        endcase
    end

    // While reset is held the state already reads FETCH; the gating keeps its
    // fetch request and write enables from reaching memory or the PC/IR.
    assign bus.mem_req    = mem_req & rst_n;
    assign bus.pc_write   = pc_wr & rst_n;
    assign bus.ir_write   = ir_wr & rst_n;
    assign bus.alu_func   = func;
    assign bus.alu_src_a  = src_a;
    assign bus.alu_src_b  = src_b;
    assign bus.pc_src     = pc_src;
    assign bus.mem_we     = mem_we;
    assign bus.iord       = iord;
    assign bus.reg_write  = reg_wr;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.trap       = trap;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed vectors for mc_ctrl_fsm. A per-cycle table of
// inputs and hand-computed outputs walks several instruction types; short
// hand-written sequences cover trap persistence, addi overflow handling and
// asynchronous reset during a memory write.
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst_n;

    mc_ctrl_if bus ();

    mc_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       ov;
        logic       mr;
    } vec_t;

    vec_t        vec_q[$];
    logic [23:0] exp_q[$];
    int          n_cmp;
    int          n_fail;

    // packed order: state, func, src_a, src_b, pc_write, pc_src, mem_req,
    // mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg, trap
    function automatic logic [23:0] actual();
        return {bus.state, bus.alu_func, bus.alu_src_a, bus.alu_src_b,
                bus.pc_write, bus.pc_src, bus.mem_req, bus.mem_we, bus.iord,
                bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.trap};
    endfunction

    task automatic v(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic ov, input logic mr, input logic [3:0] st,
                     input logic [5:0] f, input logic sa, input logic [1:0] sb,
                     input logic pw, input logic [1:0] ps, input logic mq,
                     input logic we, input logic io, input logic ir,
                     input logic rw, input logic rd, input logic m2,
                     input logic tr);
        vec_t x;
        x.rst = r; x.op = op; x.funct = fn; x.ov = ov; x.mr = mr;
        vec_q.push_back(x);
        exp_q.push_back({st, f, sa, sb, pw, ps, mq, we, io, ir, rw, rd, m2, tr});
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic ov, input logic mr);
        bus.op = op; bus.funct = fn; bus.alu_ov = ov; bus.mem_ready = mr;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(6'h00, 6'h20, 1'b0, 1'b1);

        //  r  op     fn     ov mr   st  func  sa sb pw ps mq we io ir rw rd m2 tr
        v(0, 6'h00, 6'h20, 0, 1,  0, 6'h02, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add
        v(1, 6'h00, 6'h20, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h00, 6'h20, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h20, 0, 1,  6, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h20, 0, 1,  7, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // sub, one fetch wait, mem_ready low in DECODE
        v(1, 6'h00, 6'h22, 0, 0,  0, 6'h02, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h22, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h00, 6'h22, 0, 0,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h22, 0, 1,  6, 6'h04, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h22, 0, 1,  7, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // lw with two wait cycles in MEM_RD
        v(1, 6'h23, 6'h00, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h23, 6'h00, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h23, 6'h00, 0, 0,  2, 6'h02, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h23, 6'h00, 0, 0,  3, 6'h02, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        v(1, 6'h23, 6'h00, 0, 0,  3, 6'h02, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        v(1, 6'h23, 6'h00, 0, 1,  3, 6'h02, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        v(1, 6'h23, 6'h00, 0, 1,  4, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        // sw
        v(1, 6'h2b, 6'h00, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h2b, 6'h00, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h2b, 6'h00, 0, 1,  2, 6'h02, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h2b, 6'h00, 0, 1,  5, 6'h02, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        // beq taken
        v(1, 6'h04, 6'h00, 1, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h04, 6'h00, 1, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h04, 6'h00, 1, 1,  8, 6'h23, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // bne not taken
        v(1, 6'h05, 6'h00, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h05, 6'h00, 0, 0,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h05, 6'h00, 0, 1,  8, 6'h21, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // j
        v(1, 6'h02, 6'h00, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h02, 6'h00, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h02, 6'h00, 0, 1,  9, 6'h02, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        // ori with alu_ov high (ignored)
        v(1, 6'h0d, 6'h00, 1, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h0d, 6'h00, 1, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h0d, 6'h00, 1, 1, 10, 6'h10, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h0d, 6'h00, 1, 1, 11, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // sltiu
        v(1, 6'h0b, 6'h00, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h0b, 6'h00, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h0b, 6'h00, 0, 1, 10, 6'h05, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h0b, 6'h00, 0, 1, 11, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // nor
        v(1, 6'h00, 6'h27, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h00, 6'h27, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h27, 0, 1,  6, 6'h20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h27, 0, 1,  7, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // illegal funct -> TRAP, then async reset out of it
        v(1, 6'h00, 6'h3f, 0, 1,  0, 6'h02, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        v(1, 6'h00, 6'h3f, 0, 1,  1, 6'h02, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h3f, 0, 1,  6, 6'h02, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1, 6'h00, 6'h3f, 0, 1, 12, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v(1, 6'h00, 6'h3f, 0, 1, 12, 6'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v(0, 6'h00, 6'h3f, 0, 1,  0, 6'h02, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vec_q.size(); i++) begin
            rst_n = vec_q[i].rst;
            drive(vec_q[i].op, vec_q[i].funct, vec_q[i].ov, vec_q[i].mr);
            #1;
            n_cmp++;
            if (actual() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL vec[%0d] got %06h want %06h", i, actual(), exp_q[i]);
            end
            @(negedge clk);
        end

        // unknown opcode: TRAP after DECODE, held, cleared only by reset
        rst_n = 1'b1;
        drive(6'h3f, 6'h00, 1'b0, 1'b1);
        #1 chk("bad_op_fetch", {28'd0, bus.state}, 32'd0);
        @(negedge clk);
        #1 chk("bad_op_decode", {28'd0, bus.state}, 32'd1);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1 chk("trap_hold", {27'd0, bus.trap, bus.state}, {27'd0, 1'b1, 4'd12});
            @(negedge clk);
        end
        #3 rst_n = 1'b0;
        #1 chk("trap_reset", {27'd0, bus.trap, bus.state}, 32'd0);
        @(negedge clk);

        // addi with overflow
        rst_n = 1'b1;
        drive(6'h08, 6'h00, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1 chk("addi_exec", {22'd0, bus.state, bus.alu_func}, {22'd0, 4'd10, 6'h02});
        @(negedge clk);
`ifdef OVF_TRAP_EN
        #1 chk("addi_ovf", {26'd0, bus.reg_write, bus.trap, bus.state},
               {26'd0, 1'b0, 1'b1, 4'd12});
`else
        #1 chk("addi_ovf", {26'd0, bus.reg_write, bus.trap, bus.state},
               {26'd0, 1'b1, 1'b0, 4'd11});
`endif
        rst_n = 1'b0;
        @(negedge clk);

        // reset asserted while MEM_WR is waiting on memory
        rst_n = 1'b1;
        drive(6'h2b, 6'h00, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1 chk("sw_wait", {26'd0, bus.mem_req, bus.mem_we, bus.state},
               {26'd0, 1'b1, 1'b1, 4'd5});
        @(negedge clk);
        #1 chk("sw_hold", {28'd0, bus.state}, 32'd5);
        #2 rst_n = 1'b0;
        #1 chk("sw_async_rst", {26'd0, bus.mem_req, bus.mem_we, bus.state}, 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
